// File: rtl/ibex_avalon_data_bridge.sv
// ibex_avalon_data_bridge: Ibex data port to Avalon-MM master bridge with in-order responses.
// Define IBEX_AVALON_BUS_ERR_EN to return avm_response errors on data_err_o.
module ibex_avalon_data_bridge #(
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          WordAddr       = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   output logic [31:0] data_rdata_o,
   output logic [31:0] avm_address,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   output logic        avm_read,
   output logic        avm_write,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic [1:0]  avm_response,
   output logic        protocol_err_o
);
   localparam int unsigned CW = $clog2(MaxOutstanding + 1);
   logic [CW-1:0] rd_cnt, wr_cnt;
   logic [CW:0]   in_flight;
   logic          issue_ok, rd_acc, wr_acc, rd_ret, wr_ret, unused_in;
   assign in_flight = {1'b0, rd_cnt} + {1'b0, wr_cnt};
   // Reads may not pass outstanding writes, so every pending read is older than every pending write.
   assign issue_ok = (in_flight < (CW+1)'(MaxOutstanding)) & (data_we_i | (wr_cnt == '0));
   assign avm_read = data_req_i & ~data_we_i & issue_ok;
   assign avm_write = data_req_i & data_we_i & issue_ok;
   assign avm_address = WordAddr ? {2'b00, data_addr_i[31:2]} : {data_addr_i[31:2], 2'b00};
   assign avm_byteenable = data_be_i;
   assign avm_writedata = data_wdata_i;
   assign data_gnt_o = data_req_i & issue_ok & ~avm_waitrequest;
   assign rd_acc = data_gnt_o & ~data_we_i;
   assign wr_acc = data_gnt_o & data_we_i;
   assign rd_ret = avm_readdatavalid & (rd_cnt != '0);
   // Avalon writes carry no response; they retire once all older reads have returned.
   assign wr_ret = (rd_cnt == '0) & (wr_cnt != '0);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_cnt         <= '0;
         wr_cnt         <= '0;
         data_rvalid_o  <= 1'b0;
         data_rdata_o   <= '0;
         protocol_err_o <= 1'b0;
      end else begin
         rd_cnt         <= rd_cnt + CW'(rd_acc) - CW'(rd_ret);
         wr_cnt         <= wr_cnt + CW'(wr_acc) - CW'(wr_ret);
         data_rvalid_o  <= rd_ret | wr_ret;
         data_rdata_o   <= rd_ret ? avm_readdata : '0;
         protocol_err_o <= protocol_err_o | (avm_readdatavalid & (rd_cnt == '0));
      end
   end
`ifdef IBEX_AVALON_BUS_ERR_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) data_err_o <= 1'b0;
      else data_err_o <= rd_ret & (avm_response != 2'b00);
   end
   assign unused_in = ^data_addr_i[1:0];
`else
   assign data_err_o = 1'b0;
   assign unused_in = ^{avm_response, data_addr_i[1:0]};
`endif
endmodule

// File: tb/tb_ibex_avalon_data_bridge.sv
// tb_ibex_avalon_data_bridge: directed checks of the Ibex/Avalon data bridge.
module tb_ibex_avalon_data_bridge;
   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        data_req_i = 1'b0, data_we_i = 1'b0;
   logic [3:0]  data_be_i = 4'hF;
   logic [31:0] data_addr_i = '0, data_wdata_i = '0, avm_readdata = '0;
   logic        avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
   logic [1:0]  avm_response = 2'b00;
   logic        data_gnt_o, data_rvalid_o, data_err_o, avm_read, avm_write, protocol_err_o;
   logic [31:0] data_rdata_o, avm_address, avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        b_gnt, b_rvalid, b_err, b_read, b_write, b_perr;
   logic [31:0] b_rdata, b_address, b_writedata;
   logic [3:0]  b_byteenable;
   int          n_checks = 0, n_fail = 0;
   logic        exp_err;
   always #5 clk_i = ~clk_i;
   ibex_avalon_data_bridge #(.MaxOutstanding(2), .WordAddr(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(data_req_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o),
      .data_rdata_o(data_rdata_o), .avm_address(avm_address), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_read(avm_read), .avm_write(avm_write),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .avm_readdatavalid(avm_readdatavalid), .avm_response(avm_response),
      .protocol_err_o(protocol_err_o));
   ibex_avalon_data_bridge #(.MaxOutstanding(2), .WordAddr(1'b0)) dut_byte (
      .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(data_req_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid), .data_err_o(b_err),
      .data_rdata_o(b_rdata), .avm_address(b_address), .avm_writedata(b_writedata),
      .avm_byteenable(b_byteenable), .avm_read(b_read), .avm_write(b_write),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .avm_readdatavalid(avm_readdatavalid), .avm_response(avm_response),
      .protocol_err_o(b_perr));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask
   initial begin
`ifdef IBEX_AVALON_BUS_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      tick();
      tick();
      chk("rst_rvalid", data_rvalid_o, 0);
      chk("rst_rdata", data_rdata_o, 0);
      chk("rst_err", data_err_o, 0);
      chk("rst_perr", protocol_err_o, 0);
      chk("rst_gnt_idle", data_gnt_o, 0);
      rst_ni = 1'b1;
      tick();
      // single read, readdatavalid two cycles after grant
      data_req_i = 1'b1; data_addr_i = 32'h10; #1;
      chk("r1_addr", avm_address, 32'h4);
      chk("r1_addr_byte", b_address, 32'h10);
      chk("r1_read", avm_read, 1);
      chk("r1_write", avm_write, 0);
      chk("r1_gnt", data_gnt_o, 1);
      tick();
      data_req_i = 1'b0;
      chk("r1_wait1", data_rvalid_o, 0);
      tick();
      avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF; #1;
      chk("r1_wait2", data_rvalid_o, 0);
      tick();
      avm_readdatavalid = 1'b0;
      chk("r1_rvalid", data_rvalid_o, 1);
      chk("r1_rdata", data_rdata_o, 32'hDEADBEEF);
      chk("r1_err", data_err_o, 0);
      tick();
      chk("r1_rvalid_drop", data_rvalid_o, 0);
      chk("r1_rdata_drop", data_rdata_o, 0);
      // three back-to-back reads against MaxOutstanding=2
      data_req_i = 1'b1; data_addr_i = 32'h100; #1;
      chk("b_gnt1", data_gnt_o, 1);
      tick();
      data_addr_i = 32'h104; #1;
      chk("b_gnt2", data_gnt_o, 1);
      tick();
      data_addr_i = 32'h108; #1;
      chk("b_gnt3_full", data_gnt_o, 0);
      chk("b_read_full", avm_read, 0);
      tick();
      chk("b_gnt3_full2", data_gnt_o, 0);
      tick();
      avm_readdatavalid = 1'b1; avm_readdata = 32'hA1; #1;
      chk("b_gnt3_at_rdv", data_gnt_o, 0);
      tick();
      avm_readdata = 32'hB2; #1;
      chk("b_gnt3", data_gnt_o, 1);
      chk("b_resp1", data_rdata_o, 32'hA1);
      chk("b_rvalid1", data_rvalid_o, 1);
      tick();
      data_req_i = 1'b0; avm_readdata = 32'hC3; #1;
      chk("b_resp2", data_rdata_o, 32'hB2);
      chk("b_rvalid2", data_rvalid_o, 1);
      tick();
      avm_readdatavalid = 1'b0;
      chk("b_resp3", data_rdata_o, 32'hC3);
      chk("b_rvalid3", data_rvalid_o, 1);
      tick();
      chk("b_idle", data_rvalid_o, 0);
      chk("b_perr", protocol_err_o, 0);
      // read, write, read: write retires only after the read response
      data_req_i = 1'b1; data_addr_i = 32'h200; #1;
      chk("rwr_gnt_r1", data_gnt_o, 1);
      tick();
      data_we_i = 1'b1; data_addr_i = 32'h204; data_wdata_i = 32'h55; #1;
      chk("rwr_gnt_w", data_gnt_o, 1);
      chk("rwr_write", avm_write, 1);
      tick();
      data_we_i = 1'b0; data_addr_i = 32'h208; #1;
      chk("rwr_gnt_r2_blk", data_gnt_o, 0);
      chk("rwr_no_wresp", data_rvalid_o, 0);
      tick();
      avm_readdatavalid = 1'b1; avm_readdata = 32'h77; #1;
      chk("rwr_gnt_r2_blk2", data_gnt_o, 0);
      tick();
      avm_readdatavalid = 1'b0;
      chk("rwr_rresp", data_rdata_o, 32'h77);
      chk("rwr_rresp_v", data_rvalid_o, 1);
      chk("rwr_gnt_r2_blk3", data_gnt_o, 0);
      tick();
      chk("rwr_wresp_v", data_rvalid_o, 1);
      chk("rwr_wresp_d", data_rdata_o, 0);
      chk("rwr_gnt_r2", data_gnt_o, 1);
      tick();
      data_req_i = 1'b0;
      avm_readdatavalid = 1'b1; avm_readdata = 32'h88;
      tick();
      avm_readdatavalid = 1'b0;
      chk("rwr_r2_resp", data_rdata_o, 32'h88);
      tick();
      // write stalled by waitrequest for five cycles
      data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h303; data_wdata_i = 32'hCAFEF00D;
      data_be_i = 4'h3; avm_waitrequest = 1'b1; #1;
      chk("wt_addr", avm_address, 32'hC0);
      chk("wt_addr_byte", b_address, 32'h300);
      chk("wt_wdata", avm_writedata, 32'hCAFEF00D);
      chk("wt_be", avm_byteenable, 4'h3);
      for (int i = 0; i < 5; i++) begin
         chk("wt_write_held", avm_write, 1);
         chk("wt_gnt_low", data_gnt_o, 0);
         tick();
      end
      chk("wt_no_resp", data_rvalid_o, 0);
      avm_waitrequest = 1'b0; #1;
      chk("wt_gnt", data_gnt_o, 1);
      tick();
      data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h400; #1;
      chk("wt_read_blk", data_gnt_o, 0);
      chk("wt_read_blk_rd", avm_read, 0);
      chk("wt_rvalid_wait", data_rvalid_o, 0);
      tick();
      chk("wt_rvalid", data_rvalid_o, 1);
      chk("wt_rdata", data_rdata_o, 0);
      chk("wt_err", data_err_o, 0);
      chk("wt_read_gnt", data_gnt_o, 1);
      tick();
      data_req_i = 1'b0;
      avm_readdatavalid = 1'b1; avm_readdata = 32'h1234; avm_response = 2'b10;
      tick();
      avm_readdatavalid = 1'b0; avm_response = 2'b00;
      chk("be_rvalid", data_rvalid_o, 1);
      chk("be_rdata", data_rdata_o, 32'h1234);
      chk("be_err", data_err_o, {31'b0, exp_err});
      tick();
      chk("be_err_drop", data_err_o, 0);
      // unsolicited readdatavalid is dropped and flagged until reset
      avm_readdatavalid = 1'b1; avm_readdata = 32'h999;
      tick();
      avm_readdatavalid = 1'b0;
      chk("un_perr", protocol_err_o, 1);
      chk("un_no_rvalid", data_rvalid_o, 0);
      tick();
      chk("un_perr_held", protocol_err_o, 1);
      rst_ni = 1'b0; #1;
      chk("un_perr_rst", protocol_err_o, 0);
      tick();
      rst_ni = 1'b1;
      tick();
      chk("un_perr_after", protocol_err_o, 0);
      // reset with a read outstanding: late response becomes unsolicited
      data_req_i = 1'b1; data_addr_i = 32'h500; #1;
      chk("mr_gnt", data_gnt_o, 1);
      tick();
      data_req_i = 1'b0;
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      avm_readdatavalid = 1'b1; avm_readdata = 32'hBAD;
      tick();
      avm_readdatavalid = 1'b0;
      chk("mr_perr", protocol_err_o, 1);
      chk("mr_no_rvalid", data_rvalid_o, 0);
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
